// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_reset_sequencer_pkg;

    typedef enum logic [2:0] {
        PllRst   = 3'd0,
        WaitLock = 3'd1,
        Stable   = 3'd2,
        Run      = 3'd3,
        Fault    = 3'd4
    } state_e;

    // Bits needed to hold values 0..value-1; never less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << width) < 64'(value)) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchronizer with a synchronous reset to a configurable value.
module pll_reset_sequencer_sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, waits for a stable lock, then releases the system reset.
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int unsigned PLL_RESET_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pll_lock_i,
    input  logic       ext_rstn_i,
    output logic       pll_resetb_o,
    output logic       sys_rstn_o,
    output logic       pll_locked_o,
    output logic       fault_o,
    output logic [3:0] retry_cnt_o
);

    localparam int unsigned MAX_AB  = (PLL_RESET_CYCLES > LOCK_STABLE_CYCLES) ?
                                      PLL_RESET_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ?
                                      MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = clog2(MAX_CYC + 1);

    logic             lock_s;
    logic             ext_s;
    state_e           state;
    state_e           state_next;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       retry_cnt;
    logic [3:0]       retry_next;
    logic             fault;
    logic             fault_next;
    logic             pll_resetb;
    logic             sys_rstn;

    pll_reset_sequencer_sync_2ff #(
        .RESET_VAL (1'b0)
    ) u_lock_sync (
        .clk (clk_i),
        .rst (rst_i),
        .d   (pll_lock_i),
        .q   (lock_s)
    );

    pll_reset_sequencer_sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_ext_sync (
        .clk (clk_i),
        .rst (rst_i),
        .d   (ext_rstn_i),
        .q   (ext_s)
    );

    always_comb begin
        state_next = state;
        retry_next = retry_cnt;
        fault_next = fault;
        if (!ext_s) begin
            state_next = PllRst;
            retry_next = 4'd0;
            fault_next = 1'b0;
        end else begin
            case (state)
                PllRst: begin
                    if (cnt == CNT_W'(PLL_RESET_CYCLES - 1)) state_next = WaitLock;
                end
                WaitLock: begin
                    if (lock_s) begin
                        state_next = Stable;
                    end else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        if (retry_cnt < 4'(MAX_RETRIES)) begin
                            retry_next = retry_cnt + 4'd1;
                            state_next = PllRst;
                        end else begin
                            fault_next = 1'b1;
                            state_next = Fault;
                        end
                    end
                end
                Stable: begin
                    if (!lock_s) begin
                        state_next = WaitLock;
                    end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                        state_next = Run;
                    end
                end
                Run: begin
                    // Lock loss in RUN re-waits for lock without pulsing the PLL.
                    if (!lock_s) begin
                        state_next = WaitLock;
                        retry_next = 4'd0;
                    end
                end
                Fault:   fault_next = 1'b1;
                default: state_next = PllRst;
            endcase
        end
    end

    // Outputs are decoded from the next state so they move on the same edge as the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= PllRst;
            cnt        <= '0;
            retry_cnt  <= 4'd0;
            fault      <= 1'b0;
            pll_resetb <= 1'b0;
            sys_rstn   <= 1'b0;
        end else begin
            state     <= state_next;
            retry_cnt <= retry_next;
            fault     <= fault_next;
            if (state_next != state || !ext_s) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
            pll_resetb <= (state_next == WaitLock) || (state_next == Stable) ||
                          (state_next == Run);
            sys_rstn   <= (state_next == Run);
        end
    end

    assign pll_resetb_o = pll_resetb;
    assign sys_rstn_o   = sys_rstn;
    assign pll_locked_o = lock_s;
    assign fault_o      = fault;
    assign retry_cnt_o  = retry_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small cycle parameters.
module tb_pll_reset_sequencer;

    logic       clk_i;
    logic       rst_i;
    logic       pll_lock_i;
    logic       ext_rstn_i;
    logic       pll_resetb_o;
    logic       sys_rstn_o;
    logic       pll_locked_o;
    logic       fault_o;
    logic [3:0] retry_cnt_o;

    int tests = 0;
    int fails = 0;

    pll_reset_sequencer #(
        .PLL_RESET_CYCLES    (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRIES         (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pll_lock_i   (pll_lock_i),
        .ext_rstn_i   (ext_rstn_i),
        .pll_resetb_o (pll_resetb_o),
        .sys_rstn_o   (sys_rstn_o),
        .pll_locked_o (pll_locked_o),
        .fault_o      (fault_o),
        .retry_cnt_o  (retry_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Ticks until the selected output equals val; n = ticks taken, or -1 on timeout.
    // which: 0 = pll_resetb_o, 1 = sys_rstn_o, 2 = fault_o
    task automatic wait_for(input int which, input logic val, output int n);
        logic s;
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            s = (which == 0) ? pll_resetb_o : (which == 1) ? sys_rstn_o : fault_o;
            if (s === val) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        rst_i      = 1'b1;
        pll_lock_i = 1'b0;
        ext_rstn_i = 1'b1;
        repeat (3) tick();
        check("rst_resetb", 32'(pll_resetb_o), 0);
        check("rst_sysrstn", 32'(sys_rstn_o), 0);
        check("rst_fault", 32'(fault_o), 0);
        check("rst_retry", 32'(retry_cnt_o), 0);
        check("rst_locked", 32'(pll_locked_o), 0);
        rst_i = 1'b0;

        // Nominal start: the last reset edge plus three more edges keep RESETB low.
        wait_for(0, 1'b1, n);
        check("nom_resetb_low", 32'(n), 4);
        repeat (10) tick();
        pll_lock_i = 1'b1;
        tick();
        check("nom_locked_sync1", 32'(pll_locked_o), 0);
        tick();
        check("nom_locked_sync2", 32'(pll_locked_o), 1);
        wait_for(1, 1'b1, n);
        check("nom_sys_rise", 32'(n), 9);
        check("nom_fault", 32'(fault_o), 0);
        check("nom_retry", 32'(retry_cnt_o), 0);

        // Lock loss in RUN: system reset on the 3rd edge, PLL left running.
        pll_lock_i = 1'b0;
        tick();
        tick();
        check("loss_sys_hold", 32'(sys_rstn_o), 1);
        tick();
        check("loss_sys_low", 32'(sys_rstn_o), 0);
        check("loss_resetb_high", 32'(pll_resetb_o), 1);
        pll_lock_i = 1'b1;
        wait_for(1, 1'b1, n);
        check("loss_relock", 32'(n), 11);
        check("loss_retry", 32'(retry_cnt_o), 0);

        // Lock glitch while in STABLE: the 8-cycle window starts over.
        pll_lock_i = 1'b0;
        repeat (3) tick();
        pll_lock_i = 1'b1;
        repeat (5) tick();
        pll_lock_i = 1'b0;
        tick();
        pll_lock_i = 1'b1;
        tick();
        check("glitch_locked_drop", 32'(pll_locked_o), 0);
        wait_for(1, 1'b1, n);
        check("glitch_relock", 32'(n), 10);

        // External reset in RUN: seen two edges after it is first sampled.
        ext_rstn_i = 1'b0;
        tick();
        ext_rstn_i = 1'b1;
        tick();
        check("ext_run_sys_hold", 32'(sys_rstn_o), 1);
        tick();
        check("ext_run_sys_low", 32'(sys_rstn_o), 0);
        check("ext_run_resetb_low", 32'(pll_resetb_o), 0);
        wait_for(0, 1'b1, n);
        check("ext_run_resetb_pulse", 32'(n), 4);
        wait_for(1, 1'b1, n);
        check("ext_run_relock", 32'(n), 9);

        // Lock never returns: two retries then a sticky fault.
        pll_lock_i = 1'b0;
        repeat (3) tick();
        check("to_sys_low", 32'(sys_rstn_o), 0);
        wait_for(0, 1'b0, n);
        check("to1_window", 32'(n), 32);
        check("to1_retry", 32'(retry_cnt_o), 1);
        wait_for(0, 1'b1, n);
        check("to1_pulse", 32'(n), 4);
        wait_for(0, 1'b0, n);
        check("to2_window", 32'(n), 32);
        check("to2_retry", 32'(retry_cnt_o), 2);
        wait_for(0, 1'b1, n);
        check("to2_pulse", 32'(n), 4);
        wait_for(2, 1'b1, n);
        check("to3_fault_window", 32'(n), 32);
        check("to3_resetb", 32'(pll_resetb_o), 0);
        check("to3_retry", 32'(retry_cnt_o), 2);
        repeat (50) tick();
        check("fault_resetb_held", 32'(pll_resetb_o), 0);
        check("fault_sticky", 32'(fault_o), 1);
        check("fault_sys", 32'(sys_rstn_o), 0);

        // External reset out of FAULT clears fault and retries, then relocks.
        ext_rstn_i = 1'b0;
        tick();
        ext_rstn_i = 1'b1;
        tick();
        check("ext_fault_hold", 32'(fault_o), 1);
        tick();
        check("ext_fault_clr", 32'(fault_o), 0);
        check("ext_fault_retry", 32'(retry_cnt_o), 0);
        wait_for(0, 1'b1, n);
        check("ext_fault_pulse", 32'(n), 4);
        pll_lock_i = 1'b1;
        wait_for(1, 1'b1, n);
        check("ext_fault_relock", 32'(n), 11);

        // rst_i in the middle of STABLE.
        pll_lock_i = 1'b0;
        repeat (3) tick();
        pll_lock_i = 1'b1;
        repeat (5) tick();
        check("mid_stable_sys", 32'(sys_rstn_o), 0);
        check("mid_stable_resetb", 32'(pll_resetb_o), 1);
        rst_i = 1'b1;
        tick();
        check("mid_rst_resetb", 32'(pll_resetb_o), 0);
        check("mid_rst_sys", 32'(sys_rstn_o), 0);
        check("mid_rst_locked", 32'(pll_locked_o), 0);
        check("mid_rst_fault", 32'(fault_o), 0);
        check("mid_rst_retry", 32'(retry_cnt_o), 0);
        check("mid_rst_state", 32'(dut.state), 0);
        rst_i = 1'b0;
        wait_for(1, 1'b1, n);
        check("post_rst_relock", 32'(n), 13);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
